// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional macro SERIAL_ADD_OVF_EN (see serial_adder_ctrl.sv) adds a signed-overflow output.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder stepped by serial_adder_ctrl.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one bit per clock through a single fa_cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Only WIDTH-1 partial bits are stored; the final bit goes straight into sum.
    logic [WIDTH-2:0]   s_sr_q, s_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               co_q, co_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_s, fa_co;
    logic               last_bit;
    logic [WIDTH-1:0]   sum_shift;

    fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit  = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign sum_shift = {fa_s, s_sr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == ST_IDLE && start) begin
            a_sr_d  = a_in;
            b_sr_d  = b_in;
            carry_d = ci_in;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = sum_shift[WIDTH-1:1];
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            // Results are published only here, so partial sums never reach sum.
            if (last_bit) begin
                sum_d = sum_shift;
                co_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d = carry_q ^ fa_co;
`endif
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    assign sum    = sum_q;
    assign co_out = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); honours SERIAL_ADD_OVF_EN if defined.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ci_in = 1'b0;
    logic         busy, done, co_out;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .ci_in  (ci_in),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .co_out (co_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_exp = 0;
    int   n_done = 0;
    int   busy_cnt = 0;
    int   acc0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) busy_cnt++;
        else               busy_cnt = 0;
        if (done === 1'b1) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("co_out", co_out, e.co);
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", ovf, e.ov);
`endif
                chk("latency", cyc - e.acc, W);
                chk("busy_cycles", busy_cnt, W + 1);
            end
        end
    end

    task automatic push(input logic [W-1:0] s, input logic co, input logic ov, input int acc);
        exp_t e;
        e.s = s; e.co = co; e.ov = ov; e.acc = acc;
        q.push_back(e);
        n_exp++;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] s, input logic co, input logic ov);
        @(negedge clk);
        a_in = a; b_in = b; ci_in = c; start = 1'b1;
        push(s, co, ov, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_co", co_out, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        issue(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        issue(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

        // Starts during RUN and DONE must be dropped.
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h2A; ci_in = 1'b1; start = 1'b1;
        push(8'h80, 1'b0, 1'b1, cyc + 1);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        a_in = 8'hFF; b_in = 8'hFF; ci_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        a_in = 8'h11; b_in = 8'h22; ci_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("sum_hold", sum, 8'h80);
        chk("co_hold", co_out, 0);

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; ci_in = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_co", co_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // start held high: back-to-back every W+2 cycles.
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; ci_in = 1'b1; start = 1'b1;
        acc0 = cyc + 1;
        push(8'h47, 1'b0, 1'b0, acc0);
        @(negedge clk);
        a_in = 8'hC8; b_in = 8'h64; ci_in = 1'b0;
        push(8'h2C, 1'b1, 1'b0, acc0 + W + 2);
        repeat (W + 2) @(negedge clk);
        a_in = 8'hA5; b_in = 8'h5A; ci_in = 1'b1;
        push(8'h00, 1'b1, 1'b0, acc0 + 2 * (W + 2));
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        chk("done_count", n_done, n_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
